// File: rtl/alu_seq.sv
// alu_seq -- handshaked execute-stage ALU with registered result and branch
// decision, Zba shifted-add (.uw) family, signed/unsigned compares and
// branches, and an optional iterative shift-add multiplier.
//
// Build option: define ALU_MUL_EN to include the MUL op (op 16), the MUL
// state, its step counter and the multiplier datapath. Without it op 16
// decodes as ADD, busy is tied low and every op completes in one cycle.
//
// Parameters:
//   XLEN      datapath width, 32 or 64
//   MUL_STEP  multiplier bits retired per cycle, 1/2/4 (only with ALU_MUL_EN)
//
// Ports:
//   clk           clock, all state updates on rising edge
//   reset         synchronous active-high reset
//   in_valid      operation presented
//   in_ready      block can accept this cycle
//   src_a/src_b   operands (base / index-addend)
//   op            operation select
//   funct3        branch condition select
//   branch        evaluate branch condition
//   out_valid     output register holds an untaken result
//   out_ready     consumer takes the result
//   result        registered result
//   branch_taken  registered branch decision
//   busy          multi-cycle op in progress
module alu_seq #(
  parameter int XLEN     = 64,
  parameter int MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [4:0]      op,
  input  logic [2:0]      funct3,
  input  logic            branch,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            busy
);

  if (!(XLEN == 32 || XLEN == 64) ||
      !(MUL_STEP == 1 || MUL_STEP == 2 || MUL_STEP == 4) ||
      (XLEN % MUL_STEP) != 0) begin : g_bad_param
    $error("alu_seq: unsupported XLEN/MUL_STEP combination");
  end

  localparam logic [4:0] OP_ADD      = 5'd0;
  localparam logic [4:0] OP_SUB      = 5'd1;
  localparam logic [4:0] OP_AND      = 5'd2;
  localparam logic [4:0] OP_OR       = 5'd3;
  localparam logic [4:0] OP_SLT      = 5'd4;
  localparam logic [4:0] OP_XOR      = 5'd5;
  localparam logic [4:0] OP_SLTU     = 5'd6;
  localparam logic [4:0] OP_SH1ADD   = 5'd8;
  localparam logic [4:0] OP_SH2ADD   = 5'd9;
  localparam logic [4:0] OP_SH3ADD   = 5'd10;
  localparam logic [4:0] OP_ADD_UW   = 5'd11;
  localparam logic [4:0] OP_SH1ADD_UW = 5'd12;
  localparam logic [4:0] OP_SH2ADD_UW = 5'd13;
  localparam logic [4:0] OP_SH3ADD_UW = 5'd14;

  logic            accept;
  logic            drain;
  logic            is_mul;
  logic            take;
  logic            cond;
  logic [XLEN-1:0] b_uw;
  logic [XLEN-1:0] alu_res;

  assign drain    = out_valid && out_ready;
  assign in_ready = !busy && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Single-cycle datapath. Unlisted codes (and op 16 without the multiplier)
  // fall through to ADD.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    b_uw       = '0;
    b_uw[31:0] = src_b[31:0];
    alu_res    = src_a + src_b;
    case (op)
      OP_SUB:       alu_res = src_a - src_b;
      OP_AND:       alu_res = src_a & src_b;
      OP_OR:        alu_res = src_a | src_b;
      OP_SLT:       alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      OP_XOR:       alu_res = src_a ^ src_b;
      OP_SLTU:      alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      OP_SH1ADD:    alu_res = src_a + (src_b << 1);
      OP_SH2ADD:    alu_res = src_a + (src_b << 2);
      OP_SH3ADD:    alu_res = src_a + (src_b << 3);
      OP_ADD_UW:    alu_res = src_a + b_uw;
      OP_SH1ADD_UW: alu_res = src_a + (b_uw << 1);
      OP_SH2ADD_UW: alu_res = src_a + (b_uw << 2);
      OP_SH3ADD_UW: alu_res = src_a + (b_uw << 3);
      default:      alu_res = src_a + src_b;
    endcase
  end

  // Branch condition; 010/011 are not conditions and yield not-taken.
  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = (src_a == src_b);
      3'b001:  cond = (src_a != src_b);
      3'b100:  cond = ($signed(src_a) <  $signed(src_b));
      3'b101:  cond = ($signed(src_a) >= $signed(src_b));
      3'b110:  cond = (src_a <  src_b);
      3'b111:  cond = (src_a >= src_b);
      default: cond = 1'b0;
    endcase
  end

  assign take = branch && cond && !is_mul;

`ifdef ALU_MUL_EN
  localparam int STEPS = XLEN / MUL_STEP;
  localparam int CW    = $clog2(STEPS);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  logic [0:0]      state;
  logic [CW-1:0]   step_cnt;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] step_sum;
  logic [XLEN-1:0] acc_next;
  logic            mul_done;

  assign is_mul   = (op == 5'd16);
  assign busy     = (state == S_MUL);
  assign mul_done = busy && (step_cnt == LAST_STEP);

  // Partial product for the MUL_STEP low multiplier bits. The multiplicand
  // is pre-shifted each step, so bit i here carries weight 2^i.
  always_comb begin
    step_sum = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (mplier[i]) step_sum = step_sum + (mcand << i);
    end
  end

  assign acc_next = acc + step_sum;

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch and the
    // sensitivity list carries only the clock.
    if (reset) begin
      state    <= S_IDLE;
      step_cnt <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
    end else if (state == S_IDLE) begin
      if (accept && is_mul) begin
        state    <= S_MUL;
        step_cnt <= '0;
        mcand    <= src_a;
        mplier   <= src_b;
        acc      <= '0;
      end
    end else begin
      mcand    <= mcand << MUL_STEP;
      mplier   <= mplier >> MUL_STEP;
      acc      <= acc_next;
      step_cnt <= step_cnt + 1'b1;
      if (mul_done) state <= S_IDLE;
    end
  end
`else
  assign is_mul = 1'b0;
  assign busy   = 1'b0;
`endif

  // Output register. A drain clears out_valid, but a same-cycle load below
  // overrides it so accept-and-drain keeps out_valid high with the new value.
  // A MUL accept only clears it: the product arrives later on mul_done, which
  // can never coincide with an accept because in_ready is low while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      result       <= '0;
      branch_taken <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments: the later assignment in this block wins,
      // which is what makes the load override the drain.
      if (drain) out_valid <= 1'b0;
      if (accept && !is_mul) begin
        result       <= alu_res;
        branch_taken <= take;
        out_valid    <= 1'b1;
      end
`ifdef ALU_MUL_EN
      if (mul_done) begin
        result       <= acc_next;
        branch_taken <= 1'b0;
        out_valid    <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (XLEN=64). Stimulus pushes expected responses into a
// queue; an independent monitor pops and compares on every output transfer.
// Directed checks cover reset, latency, the Zba and branch cases, backpressure,
// and (with ALU_MUL_EN) multiplier timing and reset abort; then a randomized
// run with random consumer backpressure.
module tb_alu_seq;
  localparam int XLEN = 64;
  parameter  int MUL_STEP = 1;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  localparam int MUL_CYCLES = XLEN / MUL_STEP;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] src_a = '0;
  logic [XLEN-1:0] src_b = '0;
  logic [4:0]      op = '0;
  logic [2:0]      funct3 = '0;
  logic            branch = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result;
  logic            branch_taken;
  logic            busy;

  alu_seq #(.XLEN(XLEN), .MUL_STEP(MUL_STEP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .src_a(src_a), .src_b(src_b), .op(op), .funct3(funct3), .branch(branch),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .branch_taken(branch_taken), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic        taken;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  bit   rand_ready = 1'b0;
  longint unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h (t=%0t)", name, act, expv, $time);
  endtask

  // Reference model straight from the operation table.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic [4:0] o, input logic [2:0] f3, input logic br);
    exp_t e;
    logic [63:0] bu;
    bu = {32'h0, b[31:0]};
    case (o)
      5'd1:  e.res = a - b;
      5'd2:  e.res = a & b;
      5'd3:  e.res = a | b;
      5'd4:  e.res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      5'd5:  e.res = a ^ b;
      5'd6:  e.res = (a < b) ? 64'd1 : 64'd0;
      5'd8:  e.res = a + b * 64'd2;
      5'd9:  e.res = a + b * 64'd4;
      5'd10: e.res = a + b * 64'd8;
      5'd11: e.res = a + bu;
      5'd12: e.res = a + bu * 64'd2;
      5'd13: e.res = a + bu * 64'd4;
      5'd14: e.res = a + bu * 64'd8;
      5'd16: e.res = MUL_EN ? a * b : a + b;
      default: e.res = a + b;
    endcase
    e.taken = 1'b0;
    if (br && !(MUL_EN && o == 5'd16)) begin
      case (f3)
        3'd0: e.taken = (a == b);
        3'd1: e.taken = (a != b);
        3'd4: e.taken = ($signed(a) < $signed(b));
        3'd5: e.taken = ($signed(a) >= $signed(b));
        3'd6: e.taken = (a < b);
        3'd7: e.taken = (a >= b);
        default: e.taken = 1'b0;
      endcase
    end
    return e;
  endfunction

  // Present one op, wait (bounded) for acceptance, push its expectation.
  // Returns at #1 after the accepting edge.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [4:0] o,
                       input logic [2:0] f3, input logic br);
    int waited = 0;
    in_valid = 1'b1; src_a = a; src_b = b; op = o; funct3 = f3; branch = br;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 300) begin
        check("accept_timeout", 64'(waited), 64'd0);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
    exp_q.push_back(model(a, b, o, f3, br));
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Scoreboard monitor plus hold-stability check under backpressure.
  initial begin
    bit          hold_pending = 1'b0;
    logic [63:0] held_res = '0;
    logic        held_taken = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_pending = 1'b0;
      end else begin
        if (hold_pending) begin
          check("hold_result", result, held_res);
          check("hold_taken", 64'(branch_taken), 64'(held_taken));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            check("result", result, e.res);
            check("branch_taken", 64'(branch_taken), 64'(e.taken));
          end
        end
        hold_pending = out_valid && !out_ready;
        held_res     = result;
        held_taken   = branch_taken;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    longint unsigned t0;
    logic [63:0] ra, rb;
    logic [4:0]  ro;

    // Reset values.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_taken", 64'(branch_taken), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // ADD wrap, one-cycle latency.
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd0, 3'd0, 1'b0);
    check("add_latency_valid", 64'(out_valid), 64'd1);
    check("add_wrap", result, 64'd1);
    check("add_taken", 64'(branch_taken), 64'd0);

    // Zba shifted-add with and without zero-extension of b.
    issue(64'h1000, 64'hFFFF_FFFF_0000_0002, 5'd14, 3'd0, 1'b0);
    check("sh3add_uw", result, 64'h1010);
    issue(64'h1000, 64'hFFFF_FFFF_0000_0002, 5'd10, 3'd0, 1'b0);
    check("sh3add", result, 64'hFFFF_FFF8_0000_1010);

    // Branch conditions: 1 vs all-ones.
    issue(64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 3'b110, 1'b1);
    check("br_ltu", 64'(branch_taken), 64'd1);
    issue(64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 3'b100, 1'b1);
    check("br_lt", 64'(branch_taken), 64'd0);
    issue(64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 3'b010, 1'b1);
    check("br_010", 64'(branch_taken), 64'd0);

    // Backpressure: drain first, then stall an XOR result for 5 cycles.
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(64'hA5A5_0000_FFFF_1234, 64'h0F0F_F0F0_1234_1234, 5'd5, 3'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_result", result, 64'hAAAA_F0F0_EDCB_0000);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 4; i++) issue(64'(i) * 64'd100, 64'd7, 5'd0, 3'd0, 1'b0);
    check("b2b_throughput", cyc - t0, 64'd4);

`ifdef ALU_MUL_EN
    begin
      int busy_cnt = 0;
      int ready_hi = 0;
      int guard = 0;
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd16, 3'd0, 1'b0);
      forever begin
        @(negedge clk);
        if (out_valid || guard > 200) break;
        if (busy) busy_cnt++;
        if (in_ready) ready_hi++;
        guard++;
      end
      check("mul_busy_cycles", 64'(busy_cnt), 64'(MUL_CYCLES));
      check("mul_in_ready_low", 64'(ready_hi), 64'd0);
      check("mul_valid", 64'(out_valid), 64'd1);
      check("mul_result", result, 64'hFFFF_FFFF_FFFF_FFFD);
      check("mul_busy_done", 64'(busy), 64'd0);
    end
    // Reset during a MUL aborts it completely.
    begin
      int stale = 0;
      @(posedge clk); #1;
      issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 5'd16, 3'd0, 1'b0);
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_valid", 64'(out_valid), 64'd0);
      check("abort_result", result, 64'd0);
      check("abort_in_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < MUL_CYCLES + 20; i++) begin
        @(negedge clk);
        if (out_valid) stale++;
      end
      check("abort_no_stale", 64'(stale), 64'd0);
    end
`else
    issue(64'd5, 64'd7, 5'd16, 3'd0, 1'b0);
    check("op16_is_add", result, 64'd12);
    check("op16_no_busy", 64'(busy), 64'd0);
`endif

    // Randomized run with random consumer stalls.
    @(posedge clk); #1;
    rand_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = 64'($urandom_range(0, 3)) - 64'd1;
        default: rb = {$urandom, $urandom};
      endcase
      ro = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 16)) : 5'($urandom_range(0, 31));
      issue(ra, rb, ro, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
